// File: rtl/credit_send_unit_pkg.sv
// Shared network definitions for the credit send/receive units:
// credit-counter width helper, default credit-count type, link width.
package credit_send_unit_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_CREDITS = 2;

    // Counter must hold every value 0..depth inclusive.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [cred_width(DEFAULT_NUM_CREDITS)-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_send_unit_credit_counter.sv
// Saturating credit counter with sticky overflow flag; shared by send/recv.
// Ports: clk, reset, incr, decr -> count, zero, err.
module credit_counter
    import credit_send_unit_pkg::*;
#(
    parameter int p_depth = DEFAULT_NUM_CREDITS,
    parameter int p_width = cred_width(p_depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               incr,
    input  logic               decr,
    output logic [p_width-1:0] count,
    output logic               zero,
    output logic               err
);

    localparam logic [p_width-1:0] c_full = p_width'(p_depth);

    logic full;

    assign full = (count == c_full);
    assign zero = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= c_full;
            err   <= 1'b0;
        end else if (incr && !decr) begin
            // A credit beyond depth is a protocol error: saturate and flag.
            if (full)
                err <= 1'b1;
            else
                count <= count + 1'b1;
        end else if (decr && !incr && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/credit_send_unit.sv
// Drains a queue deq interface onto a credit-flow-controlled link.
// Ports: clk, reset, recv_rdy/recv_msg/recv_en (queue side),
//   send_en/send_msg (link), credit_en, credits, credit_err.
// Macro CREDIT_SEND_OUT_REG_EN: register send_en/send_msg (1-cycle latency);
//   undefined: combinational pass-through (0-cycle latency).
module credit_send_unit
    import credit_send_unit_pkg::*;
#(
    parameter int   p_data_width  = DEFAULT_DATA_WIDTH,
    parameter int   p_num_credits = DEFAULT_NUM_CREDITS,
    localparam int  c_cred_width  = cred_width(p_num_credits)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    recv_rdy,
    input  logic [p_data_width-1:0] recv_msg,
    output logic                    recv_en,
    output logic                    send_en,
    output logic [p_data_width-1:0] send_msg,
    input  logic                    credit_en,
    output logic [c_cred_width-1:0] credits,
    output logic                    credit_err
);

    logic no_credit;

    // No same-cycle bypass: a returning credit is usable next cycle.
    assign recv_en = recv_rdy & ~no_credit & ~reset;

    credit_counter #(
        .p_depth (p_num_credits),
        .p_width (c_cred_width)
    ) u_credit_counter (
        .clk   (clk),
        .reset (reset),
        .incr  (credit_en),
        .decr  (recv_en),
        .count (credits),
        .zero  (no_credit),
        .err   (credit_err)
    );

`ifdef CREDIT_SEND_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            send_en  <= 1'b0;
            send_msg <= '0;
        end else begin
            send_en <= recv_en;
            if (recv_en)
                send_msg <= recv_msg;
        end
    end
`else
    assign send_en  = recv_en;
    assign send_msg = recv_msg;
`endif

endmodule

// File: tb/tb_credit_send_unit.sv
// Self-checking bench for credit_send_unit (either CREDIT_SEND_OUT_REG_EN build).
// Scripted directed cases followed by randomized traffic against a model.
module tb_credit_send_unit;

    localparam int DW = 32;
    localparam int N  = 2;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          recv_rdy;
    logic [DW-1:0] recv_msg;
    logic          recv_en;
    logic          send_en;
    logic [DW-1:0] send_msg;
    logic          credit_en;
    logic [CW-1:0] credits;
    logic          credit_err;

    int checks   = 0;
    int failures = 0;

    credit_send_unit #(
        .p_data_width  (DW),
        .p_num_credits (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_rdy   (recv_rdy),
        .recv_msg   (recv_msg),
        .recv_en    (recv_en),
        .send_en    (send_en),
        .send_msg   (send_msg),
        .credit_en  (credit_en),
        .credits    (credits),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: credits available, sticky error, link output.
    int          m_cred;
    bit          m_err;
    bit          m_sen;
    logic [31:0] m_smsg;
    bit          model_ok = 0;

    always @(posedge clk) begin
        bit en;
        if (reset) begin
            m_cred   = N;
            m_err    = 0;
            m_sen    = 0;
            m_smsg   = 0;
            model_ok = 1;
        end else if (model_ok) begin
            en = recv_rdy && (m_cred > 0);
            m_sen = en;
            if (en)
                m_smsg = recv_msg;
            if (en && !credit_en)
                m_cred = m_cred - 1;
            else if (credit_en && !en) begin
                if (m_cred == N)
                    m_err = 1;
                else
                    m_cred = m_cred + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_en;
        if (model_ok) begin
            exp_en = recv_rdy && (m_cred > 0) && !reset;
            chk("recv_en", 32'(recv_en), 32'(exp_en));
            chk("credits", 32'(credits), 32'(m_cred));
            chk("credit_err", 32'(credit_err), 32'(m_err));
`ifdef CREDIT_SEND_OUT_REG_EN
            chk("send_en", 32'(send_en), 32'(m_sen));
            chk("send_msg", send_msg, m_smsg);
`else
            chk("send_en", 32'(send_en), 32'(exp_en));
            if (exp_en)
                chk("send_msg", send_msg, recv_msg);
`endif
        end
    end

    task automatic cyc(input bit rdy, input logic [31:0] msg,
                       input bit cen, input bit rst);
        @(posedge clk);
        #1;
        recv_rdy  = rdy;
        recv_msg  = msg;
        credit_en = cen;
        reset     = rst;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        recv_rdy  = 1'b0;
        recv_msg  = '0;
        credit_en = 1'b0;

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("idle_credits", 32'(credits), 32'd2);
            chk("idle_err", 32'(credit_err), 32'd0);
            chk("idle_send_en", 32'(send_en), 32'd0);
            chk("idle_recv_en", 32'(recv_en), 32'd0);
        end

        // Stream until credits run out.
        cyc(1, 32'hA0, 0, 0);
        chk("s0_recv_en", 32'(recv_en), 32'd1);
        chk("s0_credits", 32'(credits), 32'd2);
        cyc(1, 32'hA1, 0, 0);
        chk("s1_recv_en", 32'(recv_en), 32'd1);
        chk("s1_credits", 32'(credits), 32'd1);
`ifdef CREDIT_SEND_OUT_REG_EN
        chk("s1_send_msg", send_msg, 32'hA0);
`endif
        cyc(1, 32'hA2, 0, 0);
        chk("s2_recv_en", 32'(recv_en), 32'd0);
        chk("s2_credits", 32'(credits), 32'd0);
`ifdef CREDIT_SEND_OUT_REG_EN
        chk("s2_send_msg", send_msg, 32'hA1);
        chk("s2_send_en", 32'(send_en), 32'd1);
`endif

        // Credit return at zero: no bypass, usable next cycle.
        cyc(1, 32'hA2, 1, 0);
        chk("cr_pulse_recv_en", 32'(recv_en), 32'd0);
        cyc(1, 32'hA2, 0, 0);
        chk("cr_next_recv_en", 32'(recv_en), 32'd1);
        chk("cr_next_credits", 32'(credits), 32'd1);
        cyc(0, 0, 0, 0);
        chk("cr_back_zero", 32'(credits), 32'd0);

        // Simultaneous credit and send at credits = 1.
        cyc(0, 0, 1, 0);
        cyc(1, 32'hB0, 1, 0);
        chk("sim_recv_en", 32'(recv_en), 32'd1);
        chk("sim_credits", 32'(credits), 32'd1);
        cyc(0, 0, 0, 0);
        chk("sim_after", 32'(credits), 32'd1);
`ifdef CREDIT_SEND_OUT_REG_EN
        chk("sim_send_msg", send_msg, 32'hB0);
`endif

        // Overflow.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("ov_credits", 32'(credits), 32'd2);
        chk("ov_err_pre", 32'(credit_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("ov_err_sticky", 32'(credit_err), 32'd1);
            chk("ov_sat", 32'(credits), 32'd2);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("rst_err_clr", 32'(credit_err), 32'd0);

        // Reset during a burst at credits = 1.
        cyc(1, 32'hC0, 0, 0);
        cyc(1, 32'hC1, 0, 1);
        chk("mr_credits", 32'(credits), 32'd1);
        chk("mr_recv_en", 32'(recv_en), 32'd0);
        cyc(1, 32'hC2, 0, 0);
        chk("mr_after_credits", 32'(credits), 32'd2);
        chk("mr_resume", 32'(recv_en), 32'd1);
`ifdef CREDIT_SEND_OUT_REG_EN
        chk("mr_squash", 32'(send_en), 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom,
                $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
